// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, the ID/EX pipeline register layout and the
// per-cycle update selector used by id_ex_stage.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  typedef enum logic [2:0] {
    UPD_CLEAR,
    UPD_FLUSH,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_CAPTURE
  } upd_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] signimm;
    logic [XLEN-1:0] pcplus4;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
  } idex_t;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// Purely combinational; both source fields are compared for every opcode.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [5:0] opcode_e,
  input  logic       valid_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       valid_d,
  input  logic       hold_e,
  input  logic       flush_e,
  output logic       lu,
  output logic       stall_d
);

  logic load_e;
  logic src_match;

  always_comb begin
    load_e    = valid_e && (opcode_e == OP_LW) && (rt_e != 5'd0);
    src_match = (rt_e == rs_d) || (rt_e == rt_d);
    lu        = load_e && valid_d && src_match;
    // Under hold or flush the upstream freeze is owned by pipeline control.
    stall_d   = lu && !hold_e && !flush_e;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file addressing, operand capture, sign
// extension, load-use bubbles. Optional `STALL_CNT_EN adds a saturating stall counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DW-1:0]    instr_d,
  input  logic [DW-1:0]    pcplus4_d,
  input  logic             valid_d,
  input  logic             hold_e,
  input  logic             flush_e,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  input  logic [DW-1:0]    rd1,
  input  logic [DW-1:0]    rd2,
  output logic             stall_d,
  output logic             valid_e,
  output logic [DW-1:0]    instr_e,
  output logic [DW-1:0]    srca_e,
  output logic [DW-1:0]    srcb_e,
  output logic [DW-1:0]    signimm_e,
  output logic [DW-1:0]    pcplus4_e,
  output logic [4:0]       rs_e,
  output logic [4:0]       rt_e,
  output logic [4:0]       rd_e,
  output logic [CNT_W-1:0] stall_cnt
);

  idex_t ex_q;
  idex_t ex_next;
  upd_t  upd;
  logic  lu;

  assign ra1 = instr_d[25:21];
  assign ra2 = instr_d[20:16];

  hazard_detect u_hazard_detect (
    .opcode_e (ex_q.instr[31:26]),
    .valid_e  (ex_q.valid),
    .rt_e     (ex_q.rt),
    .rs_d     (instr_d[25:21]),
    .rt_d     (instr_d[20:16]),
    .valid_d  (valid_d),
    .hold_e   (hold_e),
    .flush_e  (flush_e),
    .lu       (lu),
    .stall_d  (stall_d)
  );

  always_comb begin
    if (!reset_n)     upd = UPD_CLEAR;
    else if (flush_e) upd = UPD_FLUSH;
    else if (hold_e)  upd = UPD_HOLD;
    else if (lu)      upd = UPD_BUBBLE;
    else              upd = UPD_CAPTURE;
  end

  always_comb begin
    ex_next = '0;
    unique case (upd)
      UPD_CLEAR: ex_next = '0;
      UPD_FLUSH, UPD_BUBBLE: begin
        ex_next       = '0;
        ex_next.instr = NOP_INSTR;
      end
      UPD_HOLD: ex_next = ex_q;
      UPD_CAPTURE: begin
        ex_next.valid   = valid_d;
        ex_next.instr   = valid_d ? instr_d : NOP_INSTR;
        ex_next.srca    = rd1;
        ex_next.srcb    = rd2;
        ex_next.signimm = sign_ext16(instr_d[15:0]);
        ex_next.pcplus4 = pcplus4_d;
        ex_next.rs      = instr_d[25:21];
        ex_next.rt      = instr_d[20:16];
        ex_next.rd      = instr_d[15:11];
      end
      default: ex_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    ex_q <= ex_next;
  end

  assign valid_e   = ex_q.valid;
  assign instr_e   = ex_q.instr;
  assign srca_e    = ex_q.srca;
  assign srcb_e    = ex_q.srcb;
  assign signimm_e = ex_q.signimm;
  assign pcplus4_e = ex_q.pcplus4;
  assign rs_e      = ex_q.rs;
  assign rt_e      = ex_q.rt;
  assign rd_e      = ex_q.rd;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if ((upd == UPD_BUBBLE) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against a rule-level reference model.
module tb_id_ex_stage;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   instr_d, pcplus4_d, rd1, rd2;
  logic          valid_d, hold_e, flush_e;
  logic [4:0]    ra1, ra2, rs_e, rt_e, rd_e;
  logic          stall_d, valid_e;
  logic [31:0]   instr_e, srca_e, srcb_e, signimm_e, pcplus4_e;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_valid;
  logic [31:0] m_instr, m_srca, m_srcb, m_imm, m_pc;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt;

  id_ex_stage #(.DW(32), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .hold_e(hold_e), .flush_e(flush_e), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .stall_d(stall_d), .valid_e(valid_e), .instr_e(instr_e),
    .srca_e(srca_e), .srcb_e(srcb_e), .signimm_e(signimm_e), .pcplus4_e(pcplus4_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_lu();
    return m_valid && valid_d && (m_instr[31:26] == 6'h23) && (m_rt != 5'd0) &&
           ((m_rt == instr_d[25:21]) || (m_rt == instr_d[20:16]));
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_CNT_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_instr = '0; m_srca = '0; m_srcb = '0; m_imm = '0;
    m_pc = '0; m_rs = '0; m_rt = '0; m_rd = '0;
  endtask

  task automatic model_step(input bit lu);
    if (!reset_n) begin
      model_clear();
      m_cnt = 0;
    end else if (flush_e) begin
      model_clear();
    end else if (hold_e) begin
      // frozen
    end else if (lu) begin
      model_clear();
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m_valid = valid_d;
      m_instr = valid_d ? instr_d : 32'd0;
      m_srca  = rd1;
      m_srcb  = rd2;
      m_imm   = 32'(int'($signed(instr_d[15:0])));
      m_pc    = pcplus4_d;
      m_rs    = instr_d[25:21];
      m_rt    = instr_d[20:16];
      m_rd    = instr_d[15:11];
    end
  endtask

  task automatic check_state();
    chk("valid_e",   {31'd0, valid_e}, {31'd0, m_valid});
    chk("instr_e",   instr_e,   m_instr);
    chk("srca_e",    srca_e,    m_srca);
    chk("srcb_e",    srcb_e,    m_srcb);
    chk("signimm_e", signimm_e, m_imm);
    chk("pcplus4_e", pcplus4_e, m_pc);
    chk("rs_e", {27'd0, rs_e}, {27'd0, m_rs});
    chk("rt_e", {27'd0, rt_e}, {27'd0, m_rt});
    chk("rd_e", {27'd0, rd_e}, {27'd0, m_rd});
    chk("stall_cnt", 32'(stall_cnt), exp_cnt());
  endtask

  // One clock: check combinational outputs, advance model, check registered state.
  task automatic cyc();
    bit lu;
    #1;
    lu = model_lu();
    chk("ra1", {27'd0, ra1}, {27'd0, instr_d[25:21]});
    chk("ra2", {27'd0, ra2}, {27'd0, instr_d[20:16]});
    if (reset_n)
      chk("stall_d", {31'd0, stall_d}, {31'd0, lu && !hold_e && !flush_e});
    model_step(lu);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc);
    instr_d = ins; valid_d = vld; rd1 = a; rd2 = b; pcplus4_d = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    int unsigned sel = $urandom_range(0, 9);
    op = (sel < 4) ? 6'h23 : (sel < 8) ? 6'h00 : 6'($urandom);
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  initial begin
    logic [31:0] snap;
    model_clear();
    m_cnt = 0;
    reset_n = 1'b0; hold_e = 1'b0; flush_e = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive($urandom, 1'b1, $urandom, $urandom, $urandom);
      hold_e = 1'($urandom); flush_e = 1'($urandom);
      cyc();
    end
    chk("reset_valid", {31'd0, valid_e}, 32'd0);
    chk("reset_instr", instr_e, 32'd0);
    reset_n = 1'b1; hold_e = 1'b0; flush_e = 1'b0;

    // capture add $3,$1,$2
    drive(32'h00221820, 1'b1, 32'd5, 32'd7, 32'h104);
    cyc();
    chk("cap_srca", srca_e, 32'd5);
    chk("cap_rd", {27'd0, rd_e}, 32'd3);
    chk("cap_pc", pcplus4_e, 32'h104);

    // load-use: lw $4,0($0) then add $5,$4,$1
    drive(32'h8C040000, 1'b1, 32'd0, 32'd0, 32'h108);
    cyc();
    drive(32'h00812820, 1'b1, 32'd11, 32'd22, 32'h10C);
    #1;
    chk("lu_stall", {31'd0, stall_d}, 32'd1);
    cyc();
    chk("lu_bubble", {31'd0, valid_e}, 32'd0);
    cyc();
    chk("lu_resolved", instr_e, 32'h00812820);

    // no false stall: lw $0 then ID uses $0
    drive(32'h8C000000, 1'b1, 32'd0, 32'd0, 32'h110);
    cyc();
    drive(32'h00000820, 1'b1, 32'd0, 32'd0, 32'h114);
    cyc();
    // lw $4 then ID uses $6,$7
    drive(32'h8C040000, 1'b1, 32'd0, 32'd0, 32'h118);
    cyc();
    drive(32'h00C74020, 1'b1, 32'd1, 32'd2, 32'h11C);
    #1;
    chk("no_false_stall", {31'd0, stall_d}, 32'd0);
    cyc();

    // flush + hold together: flush wins
    drive(32'h8C040000, 1'b1, 32'd3, 32'd4, 32'h120);
    hold_e = 1'b1; flush_e = 1'b1;
    cyc();
    chk("flush_hold_instr", instr_e, 32'd0);
    flush_e = 1'b0; hold_e = 1'b0;
    drive(32'h20A5FFF0, 1'b1, 32'd9, 32'd8, 32'h124);
    cyc();
    snap = instr_e;
    hold_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'b1, $urandom, $urandom, $urandom);
      cyc();
    end
    chk("hold_instr", instr_e, snap);
    hold_e = 1'b0;

    // sign extension boundaries
    drive(32'h20018001, 1'b1, 32'd0, 32'd0, 32'h200);
    cyc();
    chk("sext_neg", signimm_e, 32'hFFFF8001);
    drive(32'h20017FFF, 1'b1, 32'd0, 32'd0, 32'h204);
    cyc();
    chk("sext_pos", signimm_e, 32'h00007FFF);

    // drive counter past saturation with repeated load-use pairs
    for (int i = 0; i < 10; i++) begin
      drive(32'h8C040000, 1'b1, 32'd0, 32'd0, 32'h300);
      cyc();
      drive(32'h00812820, 1'b1, 32'd0, 32'd0, 32'h304);
      cyc();
      cyc();
    end
`ifdef STALL_CNT_EN
    chk("cnt_saturated", 32'(stall_cnt), 32'd7);
`else
    chk("cnt_disabled", 32'(stall_cnt), 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(rand_instr(), ($urandom_range(0, 9) != 0), $urandom, $urandom, $urandom);
      hold_e  = ($urandom_range(0, 99) < 15);
      flush_e = ($urandom_range(0, 99) < 10);
      reset_n = ($urandom_range(0, 99) >= 2);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
